// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    localparam int LOADER_DEPTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four stream bytes, least-significant first, into one 32-bit word.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_r;
    logic [31:0] shift_r;

    // Lane counter and right-shifting byte register; newest byte enters at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r  <= 2'd0;
            shift_r <= 32'd0;
        end else if (clr) begin
            lane_r  <= 2'd0;
            shift_r <= 32'd0;
        end else if (push) begin
            lane_r  <= lane_r + 2'd1;
            shift_r <= {byte_in, shift_r[31:8]};
        end else begin
            lane_r  <= lane_r;
            shift_r <= shift_r;
        end
    end

    assign word_valid = push && (lane_r == 2'd3);
    assign word       = {byte_in, shift_r[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes the instruction RAM and holds the CPU
// in reset until the loaded image passes its XOR checksum.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = LOADER_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          we,
    output logic [31:0]   waddr,
    output logic [31:0]   wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    loader_state_t state_r, state_nx;

    logic [7:0]  len_lo_r;
    logic [AW:0] len_r;
    logic [AW:0] idx_r;
    logic [7:0]  csum_r;
    logic        we_r, done_r, err_r, cpu_hold_r;
    logic [31:0] waddr_r, wdata_r;

    logic        start_s, ld_lo_s, ld_len_s, push_s, set_done_s, set_err_s;
    logic        rx_ready_s, len_ok_s, last_word_s;
    logic [15:0] n_s;
    logic        word_valid_s;
    logic [31:0] word_s;

    assign n_s         = {rx_data, len_lo_r};
    assign len_ok_s    = (n_s != 16'd0) && (n_s <= 16'(DEPTH));
    assign last_word_s = ((idx_r + IDX_ONE) == len_r);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_s),
        .push       (push_s),
        .byte_in    (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_nx   = state_r;
        start_s    = 1'b0;
        ld_lo_s    = 1'b0;
        ld_len_s   = 1'b0;
        push_s     = 1'b0;
        set_done_s = 1'b0;
        set_err_s  = 1'b0;
        rx_ready_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    start_s  = 1'b1;
                    state_nx = ST_LEN_LO;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_LEN_LO: begin
                rx_ready_s = 1'b1;
                if (rx_valid) begin
                    ld_lo_s  = 1'b1;
                    state_nx = ST_LEN_HI;
                end else begin
                    state_nx = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                rx_ready_s = 1'b1;
                if (rx_valid && len_ok_s) begin
                    ld_len_s = 1'b1;
                    state_nx = ST_DATA;
                end else if (rx_valid) begin
                    set_err_s = 1'b1;
                    state_nx  = ST_ERR;
                end else begin
                    state_nx = ST_LEN_HI;
                end
            end
            ST_DATA: begin
                rx_ready_s = 1'b1;
                push_s     = rx_valid;
                if (word_valid_s && last_word_s) begin
                    state_nx = ST_CSUM;
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_CSUM: begin
                rx_ready_s = 1'b1;
                if (rx_valid && (rx_data == csum_r)) begin
                    set_done_s = 1'b1;
                    state_nx   = ST_DONE;
                end else if (rx_valid) begin
                    set_err_s = 1'b1;
                    state_nx  = ST_ERR;
                end else begin
                    state_nx = ST_CSUM;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Length capture, checksum, word index, write port and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_r   <= 8'd0;
            len_r      <= '0;
            idx_r      <= '0;
            csum_r     <= 8'd0;
            we_r       <= 1'b0;
            waddr_r    <= 32'd0;
            wdata_r    <= 32'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            cpu_hold_r <= 1'b0;
        end else begin
            we_r <= word_valid_s;
            if (start_s) begin
                idx_r      <= '0;
                csum_r     <= 8'd0;
                done_r     <= 1'b0;
                err_r      <= 1'b0;
                cpu_hold_r <= 1'b1;
            end else begin
                if (ld_lo_s)  len_lo_r <= rx_data;
                if (ld_len_s) len_r    <= n_s[AW:0];
                if (push_s)   csum_r   <= csum_next(csum_r, rx_data);
                // The write address is taken from the index before it advances.
                if (word_valid_s) begin
                    waddr_r <= 32'({idx_r, 2'b00});
                    wdata_r <= word_s;
                    idx_r   <= idx_r + IDX_ONE;
                end
                if (set_done_s) begin
                    done_r     <= 1'b1;
                    cpu_hold_r <= 1'b0;
                end
                if (set_err_s) err_r <= 1'b1;
            end
        end
    end

    assign rx_ready     = rx_ready_s;
    assign busy         = rx_ready_s;
    assign we           = we_r;
    assign waddr        = waddr_r;
    assign wdata        = wdata_r;
    assign done         = done_r;
    assign err          = err_r;
    assign cpu_hold     = cpu_hold_r;
    assign words_loaded = idx_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus scoreboard of expected RAM writes.
module tb_imem_loader;
    import loader_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk, rst_n, start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready, we, cpu_hold, busy, done, err;
    logic [31:0]   waddr, wdata;
    logic [AW:0]   words_loaded;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          bad;
        bit          gaps;
        bit          mid_start;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && we) begin
            we_cnt++;
            check("we_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("waddr", waddr, mon_e.addr);
                check("wdata", wdata, mon_e.data);
                check("words_loaded_at_we", 32'(words_loaded), mon_e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return {8'(i), 8'hA5, 8'(~i), 8'(i * 7)};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int to;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        to = 0;
        while (!rx_ready && to < 50) begin
            @(posedge clk); #1;
            to++;
        end
        check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Start pulse with a simultaneous bogus byte that must not be consumed.
    task automatic pulse_start();
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        @(posedge clk); #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_clr_flags", {30'd0, done, err}, 32'd0);
        check("start_clr_count", 32'(words_loaded), 32'd0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        int          we0;
        we0 = we_cnt;
        cs  = 8'h00;
        pulse_start();
        send_byte(v.len[7:0], v.gaps);
        send_byte(v.len[15:8], v.gaps);
        if (v.nwords == 0) begin
            check("badlen_rx_ready", 32'(rx_ready), 32'd0);
            check("badlen_err", 32'(err), 32'd1);
            check("badlen_busy", 32'(busy), 32'd0);
            repeat (2) begin @(posedge clk); #1; end
            check("badlen_no_we", 32'(we_cnt - we0), 32'd0);
            check("badlen_hold", 32'(cpu_hold), 32'd1);
        end else begin
            if (v.mid_start) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            for (int i = 0; i < v.nwords; i++) begin
                w      = word_of(v, i);
                e.addr = 32'(i * 4);
                e.data = w;
                e.cnt  = 32'(i + 1);
                exp_q.push_back(e);
                for (int b = 0; b < 4; b++) begin
                    cs = cs ^ w[8*b +: 8];
                    send_byte(w[8*b +: 8], v.gaps);
                end
            end
            send_byte(v.bad ? (cs ^ 8'h01) : cs, v.gaps);
            @(posedge clk); #1;
            check("write_count", 32'(we_cnt - we0), 32'(v.nwords));
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            check("end_busy", 32'(busy), 32'd0);
            check("end_rx_ready", 32'(rx_ready), 32'd0);
        end
        check("end_done", 32'(done), 32'(v.exp_done));
        check("end_err", 32'(err), 32'(v.exp_err));
        check("end_hold", 32'(cpu_hold), v.exp_done ? 32'd0 : 32'd1);
        check("end_words", 32'(words_loaded), 32'(v.exp_words));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_flags"}, {26'd0, we, cpu_hold, busy, done, err, 1'b0}, 32'd0);
        check({tag, "_waddr"}, waddr, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'd2,      2,  32'h00500113, 32'h00C00193, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{16'd2,      2,  32'h00500113, 32'h00C00193, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vecs[2] = '{16'h0041,   0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h0000,   0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h0101,   0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{16'd2,      2,  32'h00500113, 32'h00C00193, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[6] = '{16'd3,      3,  32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        vecs[7] = '{16'd64,     64, 32'h00000013, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        #20;
        rx_valid = 1'b0;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k]);
            repeat (3) begin @(posedge clk); #1; end
        end

        // Abort after six bytes: one word written, then asynchronous reset.
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        mon_e.addr = 32'h0;
        mon_e.data = 32'h00500113;
        mon_e.cnt  = 32'd1;
        exp_q.push_back(mon_e);
        send_byte(8'h13, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk); #1;
        check("abort_write_seen", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("abort");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
